// File: rtl/bfloat_cmp_arb.sv
// Round-robin arbiter that time-shares one pipelined bfloat16 comparator between
// N requesters and routes each 2-bit compare code back to its owner only.
module bfloat_cmp_arb #(
    parameter int N       = 4,
    parameter int CMP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*16-1:0] req_a,
    input  logic [N*16-1:0] req_b,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rsp_valid,
    output logic [1:0]      rsp_res,
    output logic [15:0]     cmp_a,
    output logic [15:0]     cmp_b,
    input  logic [1:0]      cmp_out,
    output logic            busy
);

    localparam int          SEL_W = $clog2(N);
    localparam int unsigned NU    = N;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt, rr_ptr, rr_nxt, pick;
    logic [3:0]       cnt, cnt_nxt;
    logic             found;
    logic [N-1:0]     gnt_nxt, rv_nxt;
    logic [1:0]       res_nxt;
    logic [15:0]      a_nxt, b_nxt;
    logic [15:0]      op_a [N];
    logic [15:0]      op_b [N];
    int unsigned      idx;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign op_a[g] = req_a[16*g +: 16];
        assign op_b[g] = req_b[16*g +: 16];
    end

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = (32'(rr_ptr) + i) % NU;
            if (!found && req[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        gnt_nxt   = '0;
        rv_nxt    = '0;
        res_nxt   = rsp_res;
        a_nxt     = cmp_a;
        b_nxt     = cmp_b;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt       = pick;
                    a_nxt         = op_a[pick];
                    b_nxt         = op_b[pick];
                    gnt_nxt[pick] = 1'b1;
                    cnt_nxt       = 4'(CMP_LAT);
                    rr_nxt        = (pick == SEL_W'(N-1)) ? '0 : pick + 1'b1;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    res_nxt     = cmp_out;
                    rv_nxt[sel] = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            rr_ptr    <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_res   <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            cnt       <= cnt_nxt;
            rr_ptr    <= rr_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rv_nxt;
            rsp_res   <= res_nxt;
            cmp_a     <= a_nxt;
            cmp_b     <= b_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/bfloat_cmp_arb.md
Name: bfloat_cmp_arb

Overview:
- Round-robin arbiter and sequencer that shares a single bfloat_cmp comparator instance between N requesters.
- Each requester presents a pair of bfloat16 operands.
- The arbiter grants one requester at a time, drives the shared comparator, and waits the comparator's pipeline latency.
- It then returns the 2-bit compare code to the granted requester only.
- Sits between the bfloat16 compute lanes and the one comparator instance in the sorting/max datapath.

Parameters:
- N, 4: number of requesters (2..8).
- CMP_LAT, 1: comparator latency in clock edges from operand change to a valid cmp_out (0..15; 0 = combinational comparator).

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- req  in  N: request per requester, level-sensitive.
- req_a  in  N*16: flattened operand A; bits [16i+15:16i] belong to requester i.
- req_b  in  N*16: flattened operand B, same packing as req_a.
- gnt  out  N: one-hot, single-cycle pulse; operands of requester i were captured.
- rsp_valid  out  N: one-hot, single-cycle pulse; rsp_res is valid for requester i.
- rsp_res  out  2: shared result bus.
  - 01 = a>b, 10 = a<b, 00 = equal.
  - 11 is passed through unchanged.
- cmp_a  out  16: registered operand A to the comparator's a1 input.
- cmp_b  out  16: registered operand B to the comparator's b1 input.
- cmp_out  in  2: the comparator's out.
- busy  out  1: high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; gnt, rsp_valid, rsp_res, cmp_a, cmp_b, busy all 0; sel=0; cnt=0; rr_ptr=0. Any in-flight operation is discarded and no rsp_valid is issued for it.
- FSM states: IDLE, WAIT.
- IDLE, at an edge with req != 0:
  - Pick the first set bit searching from rr_ptr upward, wrapping mod N.
  - Register sel, cmp_a <= req_a[sel], cmp_b <= req_b[sel].
  - Assert gnt[sel] for exactly one cycle.
  - Set cnt <= CMP_LAT and rr_ptr <= (sel+1) mod N, then go to WAIT.
- IDLE with req == 0: stay in IDLE; all pulses 0.
- WAIT, cnt != 0: cnt <= cnt-1.
- WAIT, cnt == 0:
  - rsp_res <= cmp_out; rsp_valid[sel] <= 1 for one cycle; go to IDLE.
  - The next grant can occur at the following edge.
- Requests arriving during WAIT are not sampled until IDLE.
- cmp_a/cmp_b stay stable from the grant until the next grant; they are not cleared on response.
- rsp_res holds its last value until the next response.
- Latency:
  - Response: rsp_valid rises CMP_LAT+1 edges after the edge that raised gnt.
  - Throughput: one operation per CMP_LAT+2 cycles when requests are continuous.
- Requester contract:
  - Hold req and operands stable until gnt is seen; may drop req in the gnt cycle.
  - If req is still high after gnt, it counts as a new request.
  - A req dropped before being granted is simply never served; no error is raised.
- Fairness: a continuously requesting requester waits at most N-1 other operations.
- Wrap-around: rr_ptr at N-1 plus a grant gives rr_ptr = 0.
- Simultaneous events:
  - A grant and a response never occur in the same cycle.
  - The rsp_valid and gnt pulses are never both high.
- Invariants: rsp_valid and gnt are each one-hot or zero.

Test Plan:
1. N=4, CMP_LAT=1; only req[0], a=0x401D (2.456), b=0x3F8E (1.112) -> gnt=0001 for 1 cycle; rsp_valid=0001 exactly 2 edges later; rsp_res=01; busy high for 2 cycles.
2. After reset, all four requesters asserted at once, held until each one's own gnt:
   - ops: r0 0x401D/0x3F8E, r1 0xC01D/0xBF8E, r2 0x0000/0x0000, r3 0xBF99/0xBFA6.
   - Required: grants in order 0,1,2,3, spaced 3 cycles apart.
   - Required results: 01, 10, 00, 01, each routed only to the matching rsp_valid bit.
3. req[0] held high continuously, req[2] raised after the first grant -> grant sequence 0,2,0,2; requester 0 is never granted twice in a row while req[2] is pending.
4. Assert rst during WAIT -> all outputs 0 in the same cycle without waiting for an edge; no rsp_valid follows; first grant after release goes to the lowest set req bit starting at index 0.
5. Parameter sweep CMP_LAT=0 and CMP_LAT=3 with the comparator model delayed to match, ops 0xC019/0xC013 (-2.4 vs -2.3) -> rsp_res=10; rsp_valid 1 and 4 edges after gnt respectively.
6. Comparator model forced to 11 -> rsp_res=11 passed through with a normal rsp_valid pulse and normal FSM return to IDLE.
